// File: rtl/cpt_lancer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpt_lancer_if : roll-range bounds, roll button and rolled-value bundle      |
// | Revision      : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface cpt_lancer_if;
   logic [6:0] Min;
   logic [6:0] Max;
   logic       Lancer;
   logic [6:0] Valeur;
   logic       Valid;
   logic       Busy;

   modport master (
      output Min, Max, Lancer,
      input  Valeur, Valid, Busy
   );

   modport slave (
      input  Min, Max, Lancer,
      output Valeur, Valid, Busy
   );
endinterface
`default_nettype wire

// File: rtl/cpt_lancer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpt_lancer : rolling-value generator cycling through [Min, Max] while the   |
// |              roll button is held; optional deceleration selected by the     |
// |              CPT_LANCER_SLOWDOWN_EN macro.                                  |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module cpt_lancer #(
   parameter int SLOW_STEPS = 8,
   parameter int SLOW_BASE  = 4,
   parameter int DIV_W      = 16
) (
   input  wire logic   Clk,
   input  wire logic   Reset,
   cpt_lancer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROLL   = 2'd1,
      S_RESULT = 2'd2
`ifdef CPT_LANCER_SLOWDOWN_EN
      ,
      S_SLOW   = 2'd3
`endif
   } state_t;

   state_t     state_q, state_d;
   logic       sync1_q, sync2_q;
   logic [6:0] valeur_q, valeur_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       l_s;
   logic [6:0] step_val;

   assign l_s = sync2_q;

   // Out-of-range or at-top values wrap to Min, which also pins the output when Min > Max.
   assign step_val = (valeur_q >= bus.Max || valeur_q < bus.Min) ? bus.Min : valeur_q + 7'd1;

`ifdef CPT_LANCER_SLOWDOWN_EN
   localparam logic [3:0] c_last_step = 4'(SLOW_STEPS - 1);

   logic [DIV_W-1:0] presc_q, presc_d;
   logic [DIV_W-1:0] presc_reload;
   logic [3:0]       idx_q, idx_d;
   logic [4:0]       idx_next;

   assign idx_next     = {1'b0, idx_q} + 5'd1;
   assign presc_reload = (DIV_W'(SLOW_BASE) << idx_next) - DIV_W'(1);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end
`else
   localparam int c_unused_cfg = SLOW_STEPS + SLOW_BASE + DIV_W;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         valeur_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= bus.Lancer;
         sync2_q  <= sync1_q;
         valeur_q <= valeur_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      valeur_d = valeur_q;
`ifdef CPT_LANCER_SLOWDOWN_EN
      presc_d  = presc_q;
      idx_d    = idx_q;
`endif
      case (state_q)
         S_IDLE, S_RESULT: begin
            if (l_s) begin
               state_d  = S_ROLL;
               valeur_d = bus.Min;
            end
         end
         S_ROLL: begin
            if (l_s) begin
               valeur_d = step_val;
            end else begin
`ifdef CPT_LANCER_SLOWDOWN_EN
               state_d = S_SLOW;
               idx_d   = '0;
               presc_d = DIV_W'(SLOW_BASE - 1);
`else
               state_d = S_RESULT;
`endif
            end
         end
`ifdef CPT_LANCER_SLOWDOWN_EN
         S_SLOW: begin
            // A re-press resumes rolling from the current value without reloading Min.
            if (l_s) begin
               state_d = S_ROLL;
            end else if (presc_q == '0) begin
               valeur_d = step_val;
               idx_d    = idx_next[3:0];
               presc_d  = presc_reload;
               if (idx_q == c_last_step) begin
                  state_d = S_RESULT;
               end
            end else begin
               presc_d = presc_q - DIV_W'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      valid_d = (state_d == S_RESULT);
`ifdef CPT_LANCER_SLOWDOWN_EN
      busy_d  = (state_d == S_ROLL) || (state_d == S_SLOW);
`else
      busy_d  = (state_d == S_ROLL);
`endif
   end

   assign bus.Valeur = valeur_q;
   assign bus.Valid  = valid_q;
   assign bus.Busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cpt_lancer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpt_lancer : vector table of rolls plus hand-written corner sequences    |
// | Revision      : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_cpt_lancer;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [6:0] exp_q[$];

   cpt_lancer_if ifc();

   cpt_lancer #(
      .SLOW_STEPS(8),
      .SLOW_BASE (4),
      .DIV_W     (16)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (ifc)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [6:0] mn;
      logic [6:0] mx;
      int         hold;
      logic [6:0] fin_fast;
      logic [6:0] fin_slow;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [6:0] mstep(input logic [6:0] v, input logic [6:0] mn, input logic [6:0] mx);
      return (v >= mx || v < mn) ? mn : v + 7'd1;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_valid(input string name, input int limit, output int cyc);
      cyc = 0;
      while (ifc.Valid !== 1'b1 && cyc < limit) begin
         tick();
         cyc++;
      end
      check(name, ifc.Valid, 1);
   endtask

   task automatic run_vec(input vec_t v, input logic prev_result);
      logic [6:0] m;
      int         cyc;
      m = v.mn;
      exp_q.push_back(m);
      for (int k = 1; k < v.hold; k++) begin
         m = mstep(m, v.mn, v.mx);
         exp_q.push_back(m);
      end
      ifc.Min    = v.mn;
      ifc.Max    = v.mx;
      ifc.Lancer = 1'b1;
      for (int e = 1; e <= v.hold + 2; e++) begin
         tick();
         if (e == 2) check("valid_before_roll", ifc.Valid, prev_result);
         if (e >= 3) begin
            if (e == 3) check("valid_fall", ifc.Valid, 0);
            check("busy_roll", ifc.Busy, 1);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL roll_val: got %0d, expected nothing queued", ifc.Valeur);
            end else begin
               check("roll_val", ifc.Valeur, exp_q.pop_front());
            end
         end
         if (e == v.hold) ifc.Lancer = 1'b0;
      end
      tick();
`ifdef CPT_LANCER_SLOWDOWN_EN
      check("busy_slow", ifc.Busy, 1);
      check("valid_slow", ifc.Valid, 0);
      wait_valid("slow_done", 2000, cyc);
      check("slow_cycles", cyc, 1020);
      check("result_val", ifc.Valeur, v.fin_slow);
`else
      check("result_valid", ifc.Valid, 1);
      check("result_val", ifc.Valeur, v.fin_fast);
`endif
      check("result_busy", ifc.Busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cyc;
      vecs[0] = '{mn: 7'd1,   mx: 7'd6,   hold: 8,   fin_fast: 7'd2,   fin_slow: 7'd4};
      vecs[1] = '{mn: 7'd0,   mx: 7'd99,  hold: 102, fin_fast: 7'd1,   fin_slow: 7'd9};
      vecs[2] = '{mn: 7'd7,   mx: 7'd3,   hold: 5,   fin_fast: 7'd7,   fin_slow: 7'd7};
      vecs[3] = '{mn: 7'd5,   mx: 7'd5,   hold: 4,   fin_fast: 7'd5,   fin_slow: 7'd5};
      vecs[4] = '{mn: 7'd120, mx: 7'd127, hold: 10,  fin_fast: 7'd121, fin_slow: 7'd121};

      ifc.Min    = 7'd0;
      ifc.Max    = 7'd0;
      ifc.Lancer = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      tick();
      check("reset_valeur", ifc.Valeur, 0);
      check("reset_valid", ifc.Valid, 0);
      check("reset_busy", ifc.Busy, 0);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], (i > 0));
      end

      // Live bound change: Max drops below the current value mid-roll.
      ifc.Min    = 7'd0;
      ifc.Max    = 7'd30;
      ifc.Lancer = 1'b1;
      cyc = 0;
      while (!(ifc.Busy === 1'b1 && ifc.Valeur === 7'd20) && cyc < 100) begin
         tick();
         cyc++;
      end
      check("reach_20", ifc.Valeur, 20);
      ifc.Max = 7'd12;
      tick();
      check("live_bound_wrap", ifc.Valeur, 0);
      tick();
      check("live_bound_next", ifc.Valeur, 1);
      ifc.Lancer = 1'b0;
      wait_valid("live_bound_done", 3000, cyc);

`ifdef CPT_LANCER_SLOWDOWN_EN
      // Re-press during SLOW resumes from the current value.
      ifc.Min    = 7'd1;
      ifc.Max    = 7'd6;
      ifc.Lancer = 1'b1;
      repeat (8) tick();
      ifc.Lancer = 1'b0;
      repeat (3) tick();
      check("slow_enter_val", ifc.Valeur, 2);
      repeat (3) tick();
      check("slow_before_step", ifc.Valeur, 2);
      tick();
      check("slow_first_step", ifc.Valeur, 3);
      ifc.Lancer = 1'b1;
      repeat (2) tick();
      check("slow_hold_val", ifc.Valeur, 3);
      tick();
      check("repress_busy", ifc.Busy, 1);
      check("repress_val", ifc.Valeur, 3);
      tick();
      check("repress_step", ifc.Valeur, 4);
      ifc.Lancer = 1'b0;
      wait_valid("repress_done", 3000, cyc);
`endif

      // Asynchronous reset mid-roll, observed before any further clock edge.
      ifc.Min    = 7'd1;
      ifc.Max    = 7'd6;
      ifc.Lancer = 1'b1;
      repeat (5) tick();
      check("pre_reset_busy", ifc.Busy, 1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_valeur", ifc.Valeur, 0);
      check("async_rst_valid", ifc.Valid, 0);
      check("async_rst_busy", ifc.Busy, 0);
      ifc.Lancer = 1'b0;
      tick();
      Reset = 1'b0;
      repeat (3) tick();
      check("post_rst_busy", ifc.Busy, 0);
      check("post_rst_valid", ifc.Valid, 0);
      check("post_rst_valeur", ifc.Valeur, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpt_lancer.md
# cpt_lancer

Rolling-value generator for the dice launcher. It sits directly downstream of the face-count-to-range decoder and consumes its `Min`/`Max` bounds. While the roll button is held it cycles a value through `[Min, Max]`. On release it optionally decelerates, then freezes and flags the rolled result for the display stage.

## Interface
- `SLOW_STEPS`, default 8: number of decelerating steps after release (SLOWDOWN_EN only); legal range 1..15.
- `SLOW_BASE`, default 4: clock cycles in the first decelerating step; legal range ≥1.
- `DIV_W`, default 16: width of the interval prescaler.
- `Clk` in 1: single system clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Min` in 7: lower bound of the roll range, unsigned.
- `Max` in 7: upper bound of the roll range, unsigned.
- `Lancer` in 1: roll button, level, asynchronous to `Clk`.
- `Valeur` out 7: current or rolled value.
- `Valid` out 1: high while `Valeur` is a frozen result.
- `Busy` out 1: high in ROLL or SLOW.

## Operation
- `Lancer` passes through a 2-flop synchroniser; `L_s` denotes the synchronised level. Only `L_s` drives the FSM.
- Step rule, applied wherever a step occurs: if `Valeur >= Max` or `Valeur < Min`, then `Valeur <= Min`; else `Valeur <= Valeur + 1`.
- The step rule is 7-bit unsigned. No overflow is possible because 127 ≥ Max forces a wrap.
- If `Min > Max`, every step loads `Min`, so the output holds `Min`.
- `Min`/`Max` are sampled live on every step; a change mid-roll takes effect on the next step.
- FSM states:
  - IDLE:
    - `Valeur` holds; `Valid=0`; `Busy=0`.
    - `L_s=1` → ROLL, `Valeur <= Min`.
  - ROLL:
    - One step per clock.
    - `L_s=0` with SLOWDOWN_EN → SLOW: step index i=0, prescaler loaded with `SLOW_BASE-1`.
    - `L_s=0` without SLOWDOWN_EN → RESULT; `Valeur` does not step on that edge.
  - SLOW:
    - The prescaler counts down. At 0, one step is taken and i increments.
    - After each step the prescaler reloads with `(SLOW_BASE << i) - 1`, so interval i lasts `SLOW_BASE·2^i` cycles.
    - After step `SLOW_STEPS-1` → RESULT.
    - `L_s=1` at any time → ROLL immediately, continuing from the current `Valeur` (no reload to `Min`).
  - RESULT:
    - `Valeur` frozen; `Valid=1`; `Busy=0`.
    - `L_s=1` → ROLL, `Valeur <= Min`, `Valid` falls on that edge.
- `Busy` and `Valid` are registered and never high together.

## Timing
- Reset values: state IDLE, `Valeur=0`, `Valid=0`, `Busy=0`, synchroniser flops 0, prescaler 0, i=0.
- Reset is asynchronous. Asserting it mid-ROLL or mid-SLOW returns to the reset values immediately, with no result flagged.
- Assertion latency: with `Lancer` rising before edge 1, `L_s=1` after edge 2. Edge 3 enters ROLL with `Valeur=Min` and `Busy=1`. Edge 4 takes the first increment.
- Release latency without SLOWDOWN_EN: the value present after the release is seen at `L_s` is final. `Valid=1` is asserted 3 edges after `Lancer` falls.
- Release latency with SLOWDOWN_EN: the result is available `SLOW_BASE·(2^SLOW_STEPS − 1)` cycles after entering SLOW. With defaults this is 1020 cycles.
- Glitches on `Lancer` shorter than one clock may be missed. No debouncing is done in this block.

## Configuration
- `CPT_LANCER_SLOWDOWN_EN` defined:
  - The SLOW state, prescaler and step index are compiled in.
  - Release is followed by `SLOW_STEPS` decelerating steps.
- Not defined:
  - SLOW, prescaler and i are removed.
  - ROLL goes directly to RESULT on `L_s=0`.
  - `SLOW_STEPS`, `SLOW_BASE` and `DIV_W` are ignored.

## Test plan
- Reset: assert `Reset` asynchronously mid-ROLL → `Valeur=0`, `Valid=0`, `Busy=0` without waiting for a clock edge; the state returns to IDLE.
- Roll, no slowdown: `Min=1`, `Max=6`, with ROLL lasting 8 cycles → `Valeur` goes 1,2,3,4,5,6,1,2. Release → `Valid=1`, `Valeur=2`, `Busy=0`.
- Roll with slowdown (defaults): same roll ending at 2 → subsequent steps 3,4,5,6,1,2,3,4 at intervals 4,8,…,512. `Valid=1` with `Valeur=4` 1020 cycles after entering SLOW.
- Range 0..99: `Min=0`, `Max=99`, `Valeur` reaching 99 → next step 0. Separately, `Min=7`, `Max=3` → `Valeur` stays 7 throughout ROLL.
- Re-press: `L_s=1` during SLOW → immediate ROLL from the current value with `Busy=1`. `L_s=1` in RESULT → `Valid` falls and `Valeur=Min` on that edge.
- Live bound change: `Valeur=20` in ROLL, then `Max` changes 30→12 → next step loads `Min`.
